// File: rtl/seg_display_pkg.sv
// Shared types and constants for the two-digit seven-segment display path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seg_display_pkg;

  typedef logic [7:0] char_t;

  typedef enum logic {
    IDLE,
    SCROLL
  } state_t;

  // ASCII space shown on a digit that has no character to display.
  localparam char_t BLANK_CHAR = 8'h20;

endpackage

// File: rtl/seg_step_timer.sv
// Dwell counter: counts enabled cycles and ticks once per TICKS_PER_STEP of them.
// Latency: tick is combinational in the cycle the counter sits at its terminal count.
// Backpressure: none; a low enable holds the count, clear restarts it from zero.
module seg_step_timer #(
  parameter int TICKS_PER_STEP = 12_500_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = $clog2(TICKS_PER_STEP);
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] count;

  // Clear wins over a terminal-count tick so a restart never advances a step.
  assign tick = enable && !clear && (count == LAST);

  // Count enabled cycles, wrapping to zero on the terminal count.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/segment_text_scroller.sv
// Message buffer and scroll sequencer feeding the two digit character decoders.
// Latency: character/busy/done outputs registered, one cycle after the deciding edge.
// Backpressure: o_load_ready low (scrolling or buffer full) drops writes silently.
module segment_text_scroller
  import seg_display_pkg::*;
#(
  parameter int MSG_DEPTH      = 16,
  parameter int TICKS_PER_STEP = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_load_valid,
  input  logic [7:0] i_load_char,
  output logic       o_load_ready,
  input  logic       i_clear,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pause,
  input  logic       i_loop,
  output logic [7:0] o_char_left,
  output logic [7:0] o_char_right,
  output logic       o_busy,
  output logic       o_done
);

  // Step index and length both span 0..MSG_DEPTH; buffer index spans 0..MSG_DEPTH-1.
  localparam int KW = $clog2(MSG_DEPTH + 1);
  localparam int IW = $clog2(MSG_DEPTH);
  localparam logic [KW-1:0] DEPTH_K = KW'(MSG_DEPTH);

  state_t        state, stateNext;
  logic [KW-1:0] len, lenNext;
  logic [KW-1:0] k, kNext;
  char_t         msg [MSG_DEPTH];
  logic          writeEn;
  logic          timerClear;
  logic          timerEnable;
  logic          stepTick;
  logic          doneNext;
  char_t         leftNext, rightNext;

  assign o_load_ready = (state == IDLE) && (len < DEPTH_K);

  // Dwell only runs while scrolling and not paused.
  assign timerEnable = (state == SCROLL) && !i_pause;

  seg_step_timer #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_step_timer (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .enable(timerEnable),
    .clear (timerClear),
    .tick  (stepTick)
  );

  // Next-state logic: load/clear/start in IDLE, stop/step advance in SCROLL.
  always_comb begin
    stateNext  = state;
    lenNext    = len;
    kNext      = k;
    writeEn    = 1'b0;
    timerClear = 1'b0;
    doneNext   = 1'b0;
    case (state)
      IDLE: begin
        if (i_clear) begin
          lenNext = '0;
        end else if (i_load_valid && o_load_ready) begin
          writeEn = 1'b1;
          lenNext = len + KW'(1);
        end
        // Start qualifies on the length held before any same-cycle write.
        if (i_start && !i_clear && (len != '0)) begin
          stateNext  = SCROLL;
          kNext      = '0;
          timerClear = 1'b1;
        end
      end
      SCROLL: begin
        if (i_stop) begin
          stateNext  = IDLE;
          kNext      = '0;
          timerClear = 1'b1;
        end else if (stepTick) begin
          if (k != len) begin
            kNext = k + KW'(1);
          end else if (i_loop) begin
            kNext = '0;
          end else begin
            stateNext = IDLE;
            kNext     = '0;
            doneNext  = 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        kNext     = '0;
      end
    endcase
  end

  // Window mux for the step that will be current after this edge.
  always_comb begin
    leftNext  = BLANK_CHAR;
    rightNext = BLANK_CHAR;
    if (stateNext == SCROLL) begin
      if (kNext != '0) begin
        leftNext = msg[IW'(kNext - KW'(1))];
      end
      if (kNext != lenNext) begin
        rightNext = msg[IW'(kNext)];
      end
    end
  end

  // Control state and registered display outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= IDLE;
      len          <= '0;
      k            <= '0;
      o_char_left  <= BLANK_CHAR;
      o_char_right <= BLANK_CHAR;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      state        <= stateNext;
      len          <= lenNext;
      k            <= kNext;
      o_char_left  <= leftNext;
      o_char_right <= rightNext;
      o_busy       <= (stateNext == SCROLL);
      o_done       <= doneNext;
    end
  end

  // Message storage; contents beyond len are never displayed, so no reset needed.
  always_ff @(posedge i_Clk) begin
    if (writeEn) begin
      msg[IW'(len)] <= i_load_char;
    end
  end

endmodule

// File: tb/tb_segment_text_scroller.sv
module tb_segment_text_scroller;

  localparam int DEPTH = 4;
  localparam int TICKS = 4;
  localparam logic [7:0] BL = 8'h20;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       loadValid;
  logic [7:0] loadChar;
  logic       loadReady;
  logic       clearCmd;
  logic       startCmd;
  logic       stopCmd;
  logic       pauseLvl;
  logic       loopLvl;
  logic [7:0] charLeft;
  logic [7:0] charRight;
  logic       busy;
  logic       done;

  segment_text_scroller #(
    .MSG_DEPTH     (DEPTH),
    .TICKS_PER_STEP(TICKS)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_load_valid(loadValid),
    .i_load_char (loadChar),
    .o_load_ready(loadReady),
    .i_clear     (clearCmd),
    .i_start     (startCmd),
    .i_stop      (stopCmd),
    .i_pause     (pauseLvl),
    .i_loop      (loopLvl),
    .o_char_left (charLeft),
    .o_char_right(charRight),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 i_Clk = ~i_Clk;

  // One expected display run: a stable output tuple held for 'cycles' samples (0 = any length).
  typedef struct packed {
    logic [7:0]  left;
    logic [7:0]  right;
    logic        busy;
    logic        done;
    logic [15:0] cycles;
  } run_t;

  run_t expQ[$];
  int   passCnt  = 0;
  int   totalCnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pushRun(input logic [7:0] l, input logic [7:0] r, input logic b,
                         input logic d, input int cyc);
    run_t e;
    e.left   = l;
    e.right  = r;
    e.busy   = b;
    e.done   = d;
    e.cycles = 16'(cyc);
    expQ.push_back(e);
  endtask

  task automatic pushIdle();
    pushRun(BL, BL, 1'b0, 1'b0, 0);
  endtask

  task automatic tick();
    @(negedge i_Clk);
  endtask

  task automatic writeChar(input logic [7:0] c);
    loadValid = 1'b1;
    loadChar  = c;
    tick();
    loadValid = 1'b0;
  endtask

  task automatic doClear();
    clearCmd = 1'b1;
    tick();
    clearCmd = 1'b0;
  endtask

  task automatic doStart();
    startCmd = 1'b1;
    tick();
    startCmd = 1'b0;
  endtask

  // Monitor: run-length encodes the output tuple at each falling edge and scores each finished run.
  initial begin : monitor
    logic [17:0] prevTuple;
    logic [17:0] curTuple;
    int          runLen;
    run_t        e;
    prevTuple = {BL, BL, 1'b0, 1'b0};
    runLen    = 0;
    forever begin
      @(negedge i_Clk);
      curTuple = {charLeft, charRight, busy, done};
      if (curTuple != prevTuple) begin
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_run: got %0h for %0d cycles, none expected", prevTuple, runLen);
        end else begin
          e = expQ.pop_front();
          check("run_tuple", 32'(prevTuple), 32'({e.left, e.right, e.busy, e.done}));
          if (e.cycles != 16'd0) check("run_length", 32'(runLen), 32'(e.cycles));
        end
        prevTuple = curTuple;
        runLen    = 1;
      end else begin
        runLen++;
      end
    end
  end

  initial begin : stimulus
    i_Rst     = 1'b1;
    loadValid = 1'b0;
    loadChar  = 8'h00;
    clearCmd  = 1'b0;
    startCmd  = 1'b0;
    stopCmd   = 1'b0;
    pauseLvl  = 1'b0;
    loopLvl   = 1'b0;

    // Reset state
    tick();
    check("reset_busy", 32'(busy), 32'(1'b0));
    check("reset_done", 32'(done), 32'(1'b0));
    check("reset_left", 32'(charLeft), 32'(BL));
    check("reset_right", 32'(charRight), 32'(BL));
    check("reset_ready", 32'(loadReady), 32'(1'b1));
    i_Rst = 1'b0;
    tick();

    // "AB" single pass
    writeChar(8'h41);
    writeChar(8'h42);
    pushIdle();
    pushRun(BL, 8'h41, 1'b1, 1'b0, 4);
    pushRun(8'h41, 8'h42, 1'b1, 1'b0, 4);
    pushRun(8'h42, BL, 1'b1, 1'b0, 4);
    pushRun(BL, BL, 1'b0, 1'b1, 1);
    doStart();
    repeat (16) tick();

    // Overfill: fifth write dropped
    doClear();
    for (int i = 0; i < 5; i++) begin
      check("load_ready", 32'(loadReady), 32'(i < DEPTH));
      loadValid = 1'b1;
      loadChar  = 8'(8'h31 + i);
      tick();
    end
    loadValid = 1'b0;
    pushIdle();
    pushRun(BL, 8'h31, 1'b1, 1'b0, 4);
    pushRun(8'h31, 8'h32, 1'b1, 1'b0, 4);
    pushRun(8'h32, 8'h33, 1'b1, 1'b0, 4);
    pushRun(8'h33, 8'h34, 1'b1, 1'b0, 4);
    pushRun(8'h34, BL, 1'b1, 1'b0, 4);
    pushRun(BL, BL, 1'b0, 1'b1, 1);
    doStart();
    repeat (24) tick();

    // Looping "A", then stop two cycles into the fourth period
    doClear();
    writeChar(8'h41);
    loopLvl = 1'b1;
    pushIdle();
    for (int p = 0; p < 3; p++) begin
      pushRun(BL, 8'h41, 1'b1, 1'b0, 4);
      pushRun(8'h41, BL, 1'b1, 1'b0, 4);
    end
    pushRun(BL, 8'h41, 1'b1, 1'b0, 2);
    doStart();
    repeat (25) tick();
    stopCmd = 1'b1;
    tick();
    stopCmd = 1'b0;
    loopLvl = 1'b0;
    check("stop_busy", 32'(busy), 32'(1'b0));
    check("stop_done", 32'(done), 32'(1'b0));
    check("stop_left", 32'(charLeft), 32'(BL));
    check("stop_right", 32'(charRight), 32'(BL));

    // Pause for 7 cycles in window 1
    doClear();
    writeChar(8'h41);
    writeChar(8'h42);
    pushIdle();
    pushRun(BL, 8'h41, 1'b1, 1'b0, 4);
    pushRun(8'h41, 8'h42, 1'b1, 1'b0, 11);
    pushRun(8'h42, BL, 1'b1, 1'b0, 4);
    pushRun(BL, BL, 1'b0, 1'b1, 1);
    doStart();
    repeat (4) tick();
    pauseLvl = 1'b1;
    repeat (7) tick();
    pauseLvl = 1'b0;
    repeat (12) tick();

    // Clear beats a same-cycle load: len 0, so a later start is ignored
    clearCmd  = 1'b1;
    loadValid = 1'b1;
    loadChar  = 8'h5A;
    tick();
    clearCmd  = 1'b0;
    loadValid = 1'b0;
    doStart();
    check("clr_load_len0", 32'(busy), 32'(1'b0));

    // Clear beats a same-cycle start
    writeChar(8'h41);
    clearCmd = 1'b1;
    startCmd = 1'b1;
    tick();
    clearCmd = 1'b0;
    startCmd = 1'b0;
    check("clr_start_idle", 32'(busy), 32'(1'b0));

    // Start with empty buffer
    doStart();
    check("start_len0", 32'(busy), 32'(1'b0));

    // Load plus start with len 0: write lands, start ignored
    loadValid = 1'b1;
    loadChar  = 8'h51;
    startCmd  = 1'b1;
    tick();
    loadValid = 1'b0;
    startCmd  = 1'b0;
    check("ldstart_len0", 32'(busy), 32'(1'b0));
    pushIdle();
    pushRun(BL, 8'h51, 1'b1, 1'b0, 4);
    pushRun(8'h51, BL, 1'b1, 1'b0, 4);
    pushRun(BL, BL, 1'b0, 1'b1, 1);
    doStart();
    repeat (12) tick();

    // Reset mid-scroll
    doClear();
    writeChar(8'h41);
    writeChar(8'h42);
    pushIdle();
    pushRun(BL, 8'h41, 1'b1, 1'b0, 4);
    pushRun(8'h41, 8'h42, 1'b1, 1'b0, 2);
    doStart();
    repeat (5) tick();
    i_Rst = 1'b1;
    tick();
    i_Rst = 1'b0;
    check("rst_busy", 32'(busy), 32'(1'b0));
    check("rst_done", 32'(done), 32'(1'b0));
    check("rst_left", 32'(charLeft), 32'(BL));
    check("rst_right", 32'(charRight), 32'(BL));
    check("rst_ready", 32'(loadReady), 32'(1'b1));
    doStart();
    check("rst_start_ignored", 32'(busy), 32'(1'b0));
    writeChar(8'h43);
    pushIdle();
    pushRun(BL, 8'h43, 1'b1, 1'b0, 4);
    pushRun(8'h43, BL, 1'b1, 1'b0, 4);
    pushRun(BL, BL, 1'b0, 1'b1, 1);
    doStart();
    repeat (14) tick();

    check("runs_pending", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/segment_text_scroller.md
# segment_text_scroller

Sequencer for the two-digit seven-segment display. It stores a short ASCII message written over a simple load port. On command it scrolls the message right-to-left across a two-character window, one position per programmable dwell period. Its two registered character outputs feed one character-to-segment decoder instance per digit, so the decoders are the datapath this block schedules.

## Interface

Parameters:
- MSG_DEPTH, 16: message buffer depth in characters (2..64).
- TICKS_PER_STEP, 12_500_000: clock cycles per scroll position (0.5 s at 25 MHz); minimum 2.

Ports:
- i_Clk, in, 1: sole clock.
- i_Rst, in, 1: reset. Synchronous and active-high.
- i_load_valid, in, 1: write i_load_char into the buffer this cycle.
- i_load_char, in, 8: ASCII character to write.
- o_load_ready, out, 1: a write is accepted this cycle (state IDLE and length < MSG_DEPTH).
- i_clear, in, 1: set message length to 0 (IDLE only).
- i_start, in, 1: begin scrolling (IDLE only, length ≥ 1).
- i_stop, in, 1: abort scrolling and return to IDLE.
- i_pause, in, 1: level; while high, the dwell counter holds.
- i_loop, in, 1: level; repeat the scroll instead of finishing.
- o_char_left, out, 8: ASCII code for the left digit decoder.
- o_char_right, out, 8: ASCII code for the right digit decoder.
- o_busy, out, 1: high in SCROLL.
- o_done, out, 1: one-cycle pulse when a non-looping scroll completes.

## Operation

- Buffer: msg[0..MSG_DEPTH-1] plus length register len (0..MSG_DEPTH). A write stores to msg[len] and increments len. Writes with o_load_ready low are dropped silently.
- BLANK = 8'h20.
- Window at step k (0..len):
  - left = (k==0) ? BLANK : msg[k-1]
  - right = (k==len) ? BLANK : msg[k]
  - This gives len+1 windows. For len=1, windows are (BLANK,m0) then (m0,BLANK).
- State IDLE: outputs BLANK/BLANK, o_busy=0.
  - i_start with len≥1 moves to SCROLL with k=0 and the dwell counter cleared.
  - i_start with len=0 is ignored.
- State SCROLL: the dwell counter increments each cycle that i_pause is low. When it reaches TICKS_PER_STEP-1 it wraps to 0 and the step advances:
  - k<len: k increments.
  - k==len with i_loop high: k returns to 0.
  - k==len with i_loop low: move to IDLE and pulse o_done.
- i_stop in SCROLL: move to IDLE at once with no o_done. Buffer contents and len are kept.
- Priorities in IDLE: i_clear > i_load_valid.
  - Clear plus load in the same cycle: the write is dropped and len becomes 0.
  - Clear plus start in the same cycle: the start is ignored.
  - Load plus start in the same cycle: the write is accepted. The start sees the pre-write len; if that len is 0, the start is ignored.
- Priorities in SCROLL: i_stop > step advance > i_pause.
- i_load_valid, i_clear and i_start are ignored in SCROLL.
- Reset (including mid-scroll) forces: IDLE, len=0, k=0, counter=0, o_char_left=o_char_right=BLANK, o_busy=0, o_done=0.

## Timing

- All outputs except o_load_ready are registered. o_load_ready is a combinational decode of state and len, and reads 1 in the first cycle after reset.
- Start accepted at edge N: o_busy=1 and the window for k=0 are visible after edge N.
- Each window is held for exactly TICKS_PER_STEP unpaused cycles. Pause cycles extend the dwell one-for-one.
- The final step expires at edge M: o_done=1 for the cycle after M, together with BLANK/BLANK and o_busy=0.
- A looping scroll never asserts o_done. It shows window k=0 in the cycle after window k=len expires.
- i_stop at edge S: BLANK/BLANK and o_busy=0 after S.
- A write at edge W is visible in len after W.

## Structure

- Shared package seg_display_pkg:
  - state enum {IDLE, SCROLL}
  - BLANK_CHAR = 8'h20
  - char_t (8-bit)
- Sub-module seg_step_timer: the dwell counter, with inputs enable and clear, and a one-cycle output tick at terminal count. Parameterised by TICKS_PER_STEP, with width $clog2(TICKS_PER_STEP).
- The window mux and buffer stay in the top module. The buffer is a register array, and the step index is $clog2(MSG_DEPTH+1) bits wide.

## Test plan

All scenarios run with TICKS_PER_STEP=4 and MSG_DEPTH=4.

- Load "AB", start, i_loop=0 → windows (20,41),(41,42),(42,20), 4 cycles each. Then o_done for 1 cycle and o_busy falls in the same cycle.
- Load 5 writes → the 5th is dropped (o_load_ready=0 once len=4). Scroll shows exactly 5 windows, last = ("4th char",20).
- Scroll "A" with i_loop=1 → pattern (20,41),(41,20) repeats for 3 periods with no o_done. i_stop mid-window → BLANK/BLANK and o_busy=0 on the next cycle.
- Assert i_pause for 7 cycles during window 1 → that window lasts 11 cycles, all other windows 4.
- Same-cycle cases, each checked on the next cycle:
  - i_clear plus i_load_valid → len=0.
  - i_clear plus i_start → stays IDLE.
  - i_start with len=0 → stays IDLE.
- Assert i_Rst mid-scroll → all outputs at reset values the next cycle and len=0. A following i_start is ignored until a new load.
